// File: rtl/mtm_alu_serializer_pkg.sv
// Shared constants for the ALU serial output stage.
// Holds the frame type bits, error codes, frame geometry, serializer
// state encodings and the captured-packet record.
`timescale 1ns/1ps
package mtm_alu_serializer_pkg;

   // Frame type bit, sent right after the start bit
   localparam logic FT_DATA = 1'b0;
   localparam logic FT_CTL  = 1'b1;

   // Error codes the ALU core may place in CTL (bit7 always set)
   localparam logic [7:0] ERR_DATA = 8'hC9;
   localparam logic [7:0] ERR_CRC  = 8'hA5;
   localparam logic [7:0] ERR_OP   = 8'h93;

   // Frame geometry
   localparam int         FRAME_LEN   = 11;
   localparam int         DATA_FRAMES = 4;
   // Index of the CTL frame; error packets jump straight to it
   localparam logic [2:0] LAST_FRAME  = 3'(DATA_FRAMES);

   // Serializer states; each state is the bit currently on sout
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_TYPE  = 3'd2;
   localparam logic [2:0] ST_DATA  = 3'd3;
   localparam logic [2:0] ST_STOP  = 3'd4;

   typedef struct packed {
      logic [31:0] c;
      logic [7:0]  ctl;
   } ser_pkt_t;

endpackage

// File: rtl/mtm_alu_serializer_crc3.sv
// Combinational CRC-3, polynomial x^3+x+1, init 000, MSB first.
// Ports:
//   data [36:0] in  : {C[31:0], 1'b0, flags[3:0]}
//   crc  [2:0]  out : remainder of data*x^3 mod (x^3+x+1)
`timescale 1ns/1ps
module mtm_alu_serializer_crc3 (
   input  logic [36:0] data,
   output logic [2:0]  crc
);

   always_comb begin
      logic [2:0] r;
      logic       fb;
      r  = '0;
      fb = 1'b0;
      // Unrolled LFSR: shift in each bit, fold x^3 back as x+1
      for (int i = 36; i >= 0; i--) begin
         fb = r[2] ^ data[i];
         r  = {r[1], r[0] ^ fb, fb};
      end
      crc = r;
   end

endmodule

// File: rtl/mtm_alu_serializer.sv
// ALU output serializer.
// On a valid strobe while idle, captures C and CTL and sends them on sout
// as 11-bit frames {start 0, type, 8 payload bits MSB first, stop 1}.
// Data packets: four DATA frames (C MSB byte first) plus a CTL frame
// {0, flags, crc3}. Error packets (CTL[7]=1): one CTL frame carrying CTL.
// Ports:
//   clk   in      rising-edge clock
//   rst_n in      asynchronous active-low reset
//   C     in  32  ALU result
//   CTL   in  8   status / error byte
//   valid in      one-cycle transmit request, dropped while busy
//   sout  out     serial line, idle 1, registered
//   busy  out     high while a packet is on the line, registered
`timescale 1ns/1ps
module mtm_alu_serializer
   import mtm_alu_serializer_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] C,
   input  logic [7:0]  CTL,
   input  logic        valid,
   output logic        sout,
   output logic        busy
);

   logic [2:0] state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [2:0] frame_cnt_q, frame_cnt_d;
   ser_pkt_t   pkt_q, pkt_d;
   logic       sout_q, sout_d;
   logic       busy_q, busy_d;
   // Low during the first edge after reset release so a valid held
   // across deassertion is not taken as a request
   logic       armed_q;

   logic [2:0] crc;
   logic [7:0] payload;
   logic       frame_type;
   logic [2:0] bit_nxt;

   mtm_alu_serializer_crc3 u_crc (
      .data ({pkt_q.c, 1'b0, pkt_q.ctl[6:3]}),
      .crc  (crc)
   );

   always_comb begin
      payload = 8'h00;
      if (frame_cnt_q == LAST_FRAME) begin
         payload = pkt_q.ctl[7] ? pkt_q.ctl : {1'b0, pkt_q.ctl[6:3], crc};
      end else begin
         case (frame_cnt_q)
            3'd0:    payload = pkt_q.c[31:24];
            3'd1:    payload = pkt_q.c[23:16];
            3'd2:    payload = pkt_q.c[15:8];
            default: payload = pkt_q.c[7:0];
         endcase
      end
   end

   assign frame_type = (frame_cnt_q == LAST_FRAME) ? FT_CTL : FT_DATA;
   assign bit_nxt    = bit_cnt_q - 3'd1;

   // Next-state logic computes the bit that will be on sout next cycle
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      frame_cnt_d = frame_cnt_q;
      pkt_d       = pkt_q;
      sout_d      = sout_q;
      busy_d      = busy_q;
      case (state_q)
         ST_IDLE: begin
            sout_d = 1'b1;
            busy_d = 1'b0;
            if (valid && armed_q) begin
               pkt_d       = '{c: C, ctl: CTL};
               frame_cnt_d = CTL[7] ? LAST_FRAME : 3'd0;
               state_d     = ST_START;
               sout_d      = 1'b0;
               busy_d      = 1'b1;
            end
         end
         ST_START: begin
            state_d = ST_TYPE;
            sout_d  = frame_type;
         end
         ST_TYPE: begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd7;
            sout_d    = payload[7];
         end
         ST_DATA: begin
            if (bit_cnt_q == 3'd0) begin
               state_d = ST_STOP;
               sout_d  = 1'b1;
            end else begin
               bit_cnt_d = bit_nxt;
               sout_d    = payload[bit_nxt];
            end
         end
         ST_STOP: begin
            if (frame_cnt_q == LAST_FRAME) begin
               state_d     = ST_IDLE;
               frame_cnt_d = 3'd0;
               sout_d      = 1'b1;
               busy_d      = 1'b0;
            end else begin
               state_d     = ST_START;
               frame_cnt_d = frame_cnt_q + 3'd1;
               sout_d      = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            sout_d  = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         frame_cnt_q <= '0;
         pkt_q       <= '0;
         sout_q      <= 1'b1;
         busy_q      <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         pkt_q       <= pkt_d;
         sout_q      <= sout_d;
         busy_q      <= busy_d;
         armed_q     <= 1'b1;
      end
   end

   assign sout = sout_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Directed bench for mtm_alu_serializer: table of packets with
// hand-computed CTL payloads, plus drop, reset-release and mid-packet
// reset sequences. Outputs sampled on the falling edge.
`timescale 1ns/1ps
module tb_mtm_alu_serializer;
   import mtm_alu_serializer_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] C = '0;
   logic [7:0]  CTL = '0;
   logic        valid = 1'b0;
   logic        sout, busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mtm_alu_serializer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .C     (C),
      .CTL   (CTL),
      .valid (valid),
      .sout  (sout),
      .busy  (busy)
   );

   typedef struct {
      logic [31:0] c;
      logic [7:0]  ctl;
      logic [7:0]  exp_pay;   // expected CTL-frame payload
      string       name;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [10:0] frame(input logic t, input logic [7:0] p);
      return {1'b0, t, p, 1'b1};
   endfunction

   // Called at a falling edge with the DUT idle; returns at the falling
   // edge of the first idle cycle after the packet.
   task automatic run_pkt(input logic [31:0] c, input logic [7:0] ctl,
                          input logic [7:0] pay, input string name, input int inject_at);
      int          nfr;
      int          busy_hi;
      logic [10:0] got[5];
      logic [10:0] exp;
      logic [7:0]  byte_v;
      nfr = ctl[7] ? 1 : 5;
      C = c; CTL = ctl; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0; C = ~c; CTL = 8'h3C;
      busy_hi = 0;
      for (int f = 0; f < nfr; f++) begin
         for (int b = 0; b < FRAME_LEN; b++) begin
            @(negedge clk);
            got[f][10-b] = sout;
            if (busy === 1'b1) busy_hi++;
            if (f*FRAME_LEN + b == inject_at) begin
               valid = 1'b1; CTL = ERR_OP;
            end else begin
               valid = 1'b0;
            end
         end
      end
      valid = 1'b0;
      for (int f = 0; f < nfr; f++) begin
         byte_v = c[31-8*f -: 8];
         exp = (f == nfr-1) ? frame(FT_CTL, pay) : frame(FT_DATA, byte_v);
         check($sformatf("%s frame%0d", name, f), 64'(got[f]), 64'(exp));
      end
      check($sformatf("%s busy cycles", name), 64'(busy_hi), 64'(nfr*FRAME_LEN));
      @(negedge clk);
      check($sformatf("%s idle after", name), 64'({busy, sout}), 64'(2'b01));
   endtask

   initial begin
      int bad;
      // CRC values worked by hand using x^k mod (x^3+x+1), period 7
      vecs[0] = '{32'h00000000, 8'h00, 8'h00, "zero"};
      vecs[1] = '{32'h12345678, 8'h50, 8'h55, "pattern"};
      vecs[2] = '{32'h00000001, 8'h00, 8'h02, "lsb"};
      vecs[3] = '{32'h00000000, 8'h08, 8'h0B, "neg flag"};
      vecs[4] = '{32'hFFFFFFFF, 8'h7F, 8'h7C, "ones"};
      vecs[5] = '{32'hDEADBEEF, ERR_CRC, ERR_CRC, "err crc"};
      vecs[6] = '{32'h12345678, ERR_DATA, ERR_DATA, "err data"};
      vecs[7] = '{32'hFFFFFFFF, ERR_OP, ERR_OP, "err op"};
      vecs[8] = '{32'h00000000, 8'h80, 8'h80, "err other"};

      // Reset state
      repeat (5) @(negedge clk);
      check("reset state", 64'({busy, sout}), 64'(2'b01));
      rst_n = 1'b1;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (sout !== 1'b1 || busy !== 1'b0) bad++;
      end
      check("idle after reset", 64'(bad), 64'(0));

      // Table; consecutive packets are back-to-back with one idle cycle
      for (int i = 0; i < 9; i++)
         run_pkt(vecs[i].c, vecs[i].ctl, vecs[i].exp_pay, vecs[i].name, -1);

      // valid during an active packet is dropped
      run_pkt(32'h12345678, 8'h50, 8'h55, "drop", 5);
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (sout !== 1'b1 || busy !== 1'b0) bad++;
      end
      check("drop no restart", 64'(bad), 64'(0));

      // valid held across reset release is ignored
      rst_n = 1'b0; valid = 1'b1; CTL = ERR_CRC;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      @(negedge clk);
      check("valid at reset release", 64'({busy, sout}), 64'(2'b01));

      // Mid-packet reset at DATA bit3 of frame 2 (payload 0x56, bit3 = 0)
      C = 32'h12345678; CTL = 8'h50; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      repeat (2*FRAME_LEN + 2 + 4 + 1) @(negedge clk);
      check("pre-reset bit", 64'({busy, sout}), 64'(2'b10));
      #2 rst_n = 1'b0;
      #1 check("async reset", 64'({busy, sout}), 64'(2'b01));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (sout !== 1'b1 || busy !== 1'b0) bad++;
      end
      check("no resume", 64'(bad), 64'(0));
      run_pkt(32'h12345678, 8'h50, 8'h55, "after reset", -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
